mfcc_feature_out: RTL and testbench
===================================

# mfcc_feature_out

Output streamer at the tail of the MFCC pipeline, directly downstream of the delta stage. After the delta stage has written delta coefficients into the shared 14-bit-addressed cepstral/delta memory, this block walks every frame that has a valid delta, reads the static cepstrum and delta words, and streams them as feature vectors over a valid/ready interface to the host. It owns the memory read port while busy; all data are 32-bit IEEE-754 words and pass through unmodified.

## Interface
- ADDR_WIDTH_14, 14, memory address width: {frame[6:0], column[6:0]}
- DATA_WIDTH, 32, word width
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- out_state_en  in  1  start pulse; sampled only in IDLE
- frame_num  in  7  total frames in memory; sampled at start
- cep_num  in  7  cepstral coefficients per frame; sampled at start
- out_mem_read_addr  out  14  memory read address
- out_mem_rd_en  out  1  read strobe; data returns exactly 1 cycle later
- out_mem_data_in  in  32  memory read data
- feat_data  out  32  feature word
- feat_valid  out  1  feat_data valid
- feat_ready  in  1  sink accepts word when feat_valid && feat_ready
- feat_last_coef  out  1  qualifies final word of a frame vector
- feat_last_frame  out  1  qualifies words of the final frame
- out_busy  out  1  high from accepted start until done
- out_done  out  1  one-cycle pulse at completion

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: out_state_en=1 latches frame_num/cep_num, frame counter := 2, word counter := 0 -> READ. If frame_num<5 or cep_num=0 -> DONE directly (no reads, no words).
- Frames processed: 2 .. frame_num-3 inclusive, ascending.
- Per frame, word order: statics k=0..cep_num-1 at column k, then deltas k=0..cep_num-1 at column cep_num+1+k (7-bit add, carry-in 1; cep_num ≤ 63 so no wrap).
- READ: issue a read whenever the output buffer has a free slot counting the in-flight read; advance word/frame counters on each issued read. After the last read of the last frame -> DRAIN.
- DRAIN: wait until buffer empty and no read in flight -> DONE.
- DONE: out_done=1 for one cycle, -> IDLE.
- Output: 2-entry buffer; feat_data/flags held stable while feat_valid && !feat_ready; no word dropped or duplicated.
- feat_last_coef travels with the word (last delta of frame; last static when statics compiled out is N/A—see Configuration).
- out_state_en outside IDLE ignored. Frame_num/cep_num changes mid-run ignored.
- rst at any cycle: immediate return to IDLE, buffer flushed, in-flight read discarded.
- Reset values: out_mem_read_addr=0, out_mem_rd_en=0, feat_data=0, feat_valid=0, feat_last_coef=0, feat_last_frame=0, out_busy=0, out_done=0.

## Timing
- Start sampled at edge E0; out_mem_rd_en first high in cycle after E0; data captured at E2; feat_valid high after E2 (3-cycle start-to-first-word).
- With feat_ready held 1: one word per cycle, no bubbles, including across frame boundaries.
- feat_ready low: reads stall within 1 cycle; at most 2 words buffered.
- out_done pulses the cycle after DRAIN sees empty; out_busy falls in that same cycle.
- Total words = (frame_num-4) × 2 × cep_num.

## Configuration
- MFCC_OUT_STATIC_EN defined: per-frame vector = cep_num statics then cep_num deltas (2×cep_num words).
- Undefined: statics skipped, vector = cep_num deltas only; feat_last_coef on delta k=cep_num-1; total words halve.

## Structure
- Package mfcc_out_pkg: state enum (IDLE/READ/DRAIN/DONE), FIRST_FRAME=2, FRAME_TAIL=3, memory address field widths, delta column offset function.
- One sub-module: feat_skid_fifo (2-entry, 32-bit data + 2 flag bits, valid/ready, synchronous flush).

## Test plan
- frame_num=10, cep_num=13, ready=1 -> 156 words, first at addr {2,0}, last at {7,26}, feat_valid 3 cycles after start, out_done after last handshake.
- Same config, feat_ready random 50% -> identical word sequence, data stable during stalls, no reads with buffer full.
- frame_num=4 -> no out_mem_rd_en, out_done one cycle after DONE entry, zero words.
- rst asserted mid-frame 5 -> all outputs at reset values next cycle; fresh start restarts at frame 2.
- out_state_en pulsed while busy -> ignored, word count unchanged.
- MFCC_OUT_STATIC_EN undefined, frame_num=6, cep_num=4 -> 8 words, columns 5..8 for frames 2,3, feat_last_coef on column 8.

Source files
------------

// File: rtl/mfcc_feature_out_pkg.sv
// Shared types and constants for the MFCC feature output streamer.
// MFCC_OUT_STATIC_EN (when defined) adds static cepstra ahead of deltas in each vector.
package mfcc_out_pkg;
  localparam int ADDR_WIDTH_14 = 14;
  localparam int DATA_WIDTH    = 32;
  localparam int FRAME_W       = 7;
  localparam int COL_W         = 7;

  localparam logic [FRAME_W-1:0] FIRST_FRAME = 7'd2;
  localparam logic [FRAME_W-1:0] FRAME_TAIL  = 7'd3;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} out_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last_coef;
    logic                  last_frame;
  } feat_word_t;

  // Deltas sit one column past the statics: column cep_num+1+k.
  function automatic logic [COL_W-1:0] delta_col(input logic [COL_W-1:0] cep,
                                                 input logic [COL_W-1:0] k);
    return cep + k + 7'd1;
  endfunction
endpackage

// File: rtl/mfcc_feature_out_if.sv
// Control, memory read port and feature stream of the MFCC output streamer.
interface mfcc_feature_out_if;
  logic        out_state_en;
  logic [6:0]  frame_num;
  logic [6:0]  cep_num;
  logic [13:0] out_mem_read_addr;
  logic        out_mem_rd_en;
  logic [31:0] out_mem_data_in;
  logic [31:0] feat_data;
  logic        feat_valid;
  logic        feat_ready;
  logic        feat_last_coef;
  logic        feat_last_frame;
  logic        out_busy;
  logic        out_done;

  modport master (
    input  out_state_en, frame_num, cep_num, out_mem_data_in, feat_ready,
    output out_mem_read_addr, out_mem_rd_en, feat_data, feat_valid,
           feat_last_coef, feat_last_frame, out_busy, out_done
  );

  modport slave (
    output out_state_en, frame_num, cep_num, out_mem_data_in, feat_ready,
    input  out_mem_read_addr, out_mem_rd_en, feat_data, feat_valid,
           feat_last_coef, feat_last_frame, out_busy, out_done
  );
endinterface

// File: rtl/mfcc_feature_out_fifo.sv
// Two-entry output buffer carrying a feature word plus its frame/vector flags.
module feat_skid_fifo
  import mfcc_out_pkg::*;
(
  input  logic       clk,
  input  logic       i_flush,
  input  logic       i_valid,
  input  feat_word_t i_data,
  output logic       o_valid,
  output feat_word_t o_data,
  input  logic       i_ready,
  output logic [1:0] o_count
);
  feat_word_t r_e0, r_e1;
  logic [1:0] r_cnt;
  logic       w_push, w_pop;

  // Writer uses o_count for credit, so a push never arrives while full.
  assign w_pop  = (r_cnt != 2'd0) && i_ready;
  assign w_push = i_valid;

  always_ff @(posedge clk) begin
    if (i_flush) begin
      r_cnt <= 2'd0;
      r_e0  <= '0;
      r_e1  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_e0 <= i_data;
          else               r_e1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) r_e0 <= i_data;
          else begin
            r_e0 <= r_e1;
            r_e1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_e0;
  assign o_count = r_cnt;
endmodule

// File: rtl/mfcc_feature_out.sv
// Walks frames with valid deltas and streams cepstral/delta words to the host.
// Define MFCC_OUT_STATIC_EN to emit statics before deltas in every vector.
module mfcc_feature_out
  import mfcc_out_pkg::*;
(
  input logic               clk,
  input logic               rst,
  mfcc_feature_out_if.master bus
);
  out_state_e  r_state, w_next;
  logic [6:0]  r_fnum, r_cnum, r_frame;
  logic [7:0]  r_word;
  logic        r_inflight, r_if_lc, r_if_lf;
  logic [7:0]  w_wpf;
  logic [6:0]  w_col;
  logic        w_last_coef, w_last_frame, w_free, w_issue, w_pop;
  logic        w_fifo_valid;
  logic [1:0]  w_cnt;
  feat_word_t  w_head;

`ifdef MFCC_OUT_STATIC_EN
  assign w_wpf = {r_cnum, 1'b0};
  assign w_col = (r_word < {1'b0, r_cnum}) ? r_word[6:0]
                                           : delta_col(r_cnum, r_word[6:0] - r_cnum);
`else
  assign w_wpf = {1'b0, r_cnum};
  assign w_col = delta_col(r_cnum, r_word[6:0]);
`endif

  assign w_last_coef  = (r_word == w_wpf - 8'd1);
  assign w_last_frame = (r_frame == r_fnum - FRAME_TAIL);

  // Credit counts the in-flight read and frees the slot being popped this cycle.
  assign w_pop   = w_fifo_valid && bus.feat_ready;
  assign w_free  = ({1'b0, w_cnt} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
  assign w_issue = (r_state == READ) && w_free;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (bus.out_state_en)
               w_next = (bus.frame_num < 7'd5 || bus.cep_num == 7'd0) ? DONE : READ;
      READ:  if (w_issue && w_last_coef && w_last_frame) w_next = DRAIN;
      DRAIN: if (!w_fifo_valid && !r_inflight) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fnum     <= '0;
      r_cnum     <= '0;
      r_frame    <= '0;
      r_word     <= '0;
      r_inflight <= 1'b0;
      r_if_lc    <= 1'b0;
      r_if_lf    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      r_if_lc    <= w_last_coef;
      r_if_lf    <= w_last_frame;
      if (r_state == IDLE && bus.out_state_en) begin
        r_fnum  <= bus.frame_num;
        r_cnum  <= bus.cep_num;
        r_frame <= FIRST_FRAME;
        r_word  <= '0;
      end else if (w_issue) begin
        if (w_last_coef) begin
          r_word  <= '0;
          r_frame <= r_frame + 7'd1;
        end else begin
          r_word  <= r_word + 8'd1;
        end
      end
    end
  end

  feat_skid_fifo u_fifo (
    .clk     (clk),
    .i_flush (rst),
    .i_valid (r_inflight),
    .i_data  ({bus.out_mem_data_in, r_if_lc, r_if_lf}),
    .o_valid (w_fifo_valid),
    .o_data  (w_head),
    .i_ready (bus.feat_ready),
    .o_count (w_cnt)
  );

  assign bus.out_mem_rd_en     = w_issue;
  assign bus.out_mem_read_addr = w_issue ? {r_frame, w_col} : 14'd0;
  assign bus.feat_valid        = w_fifo_valid;
  assign bus.feat_data         = w_head.data;
  assign bus.feat_last_coef    = w_head.last_coef;
  assign bus.feat_last_frame   = w_head.last_frame;
  assign bus.out_busy          = (r_state == READ) || (r_state == DRAIN);
  assign bus.out_done          = (r_state == DONE);
endmodule

// File: tb/tb_mfcc_feature_out.sv
// Directed bench for mfcc_feature_out: stream order, flags, timing, stalls, reset.
module tb_mfcc_feature_out;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mfcc_feature_out_if bus();
  mfcc_feature_out dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errs   = 0;

  function automatic logic [31:0] mword(input logic [13:0] a);
    return {4'hD, a, ~a};
  endfunction

  // Synchronous memory: data one cycle after the read strobe.
  always @(posedge clk)
    if (bus.out_mem_rd_en) bus.out_mem_data_in <= mword(bus.out_mem_read_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  {50'd0, bus.out_mem_read_addr}, 64'd0);
    chk({tag, "_rden"},  {63'd0, bus.out_mem_rd_en}, 64'd0);
    chk({tag, "_data"},  {32'd0, bus.feat_data}, 64'd0);
    chk({tag, "_valid"}, {63'd0, bus.feat_valid}, 64'd0);
    chk({tag, "_lc"},    {63'd0, bus.feat_last_coef}, 64'd0);
    chk({tag, "_lf"},    {63'd0, bus.feat_last_frame}, 64'd0);
    chk({tag, "_busy"},  {63'd0, bus.out_busy}, 64'd0);
    chk({tag, "_done"},  {63'd0, bus.out_done}, 64'd0);
  endtask

  task automatic run_stream(input int fnum, input int cep, input bit rnd, input int poke);
    logic [33:0] exp_q[$];
    logic [33:0] obs, prev_word;
    logic [6:0]  fv, cv;
    logic [13:0] a, a0;
    int wpf, idx, rd_cnt, acc_cnt, outst, max_out, first_hs, last_hs, done_cyc;
    bit hs, prev_stall;
`ifdef MFCC_OUT_STATIC_EN
    wpf = 2 * cep;
`else
    wpf = cep;
`endif
    a0 = '0;
    for (int f = 2; f <= fnum - 3; f++)
      for (int k = 0; k < wpf; k++) begin
        fv = f[6:0];
        cv = (k < cep && wpf != cep) ? k[6:0] : (wpf != cep ? cep[6:0] + 7'd1 + (k[6:0] - cep[6:0])
                                                             : cep[6:0] + 7'd1 + k[6:0]);
        a = {fv, cv};
        if (exp_q.size() == 0) a0 = a;
        exp_q.push_back({mword(a), k == wpf - 1, f == fnum - 3});
      end
    idx = 0; rd_cnt = 0; acc_cnt = 0; max_out = 0;
    first_hs = -1; last_hs = -1; done_cyc = -1; prev_stall = 0; prev_word = '0;

    @(negedge clk);
    bus.frame_num = fnum[6:0]; bus.cep_num = cep[6:0];
    bus.out_state_en = 1'b1; bus.feat_ready = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 2000; c++) begin
      bus.out_state_en = (c == poke);
      bus.feat_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (c == 1) begin
        chk("first_rden", {63'd0, bus.out_mem_rd_en}, 64'd1);
        chk("first_addr", {50'd0, bus.out_mem_read_addr}, {50'd0, a0});
      end
      if (c == 2) chk("valid_c2", {63'd0, bus.feat_valid}, 64'd0);
      if (c == 3) chk("valid_c3", {63'd0, bus.feat_valid}, 64'd1);
      obs = {bus.feat_data, bus.feat_last_coef, bus.feat_last_frame};
      hs = bus.feat_valid && bus.feat_ready;
      if (prev_stall) chk("stall_stable", {29'd0, bus.feat_valid, obs}, {29'd0, 1'b1, prev_word});
      if (hs) begin
        if (idx < exp_q.size()) chk("word", {30'd0, obs}, {30'd0, exp_q[idx]});
        else chk("extra_word", {30'd0, obs}, 64'd0);
        idx++;
        if (first_hs < 0) first_hs = c;
        last_hs = c;
      end
      if (bus.out_mem_rd_en) rd_cnt++;
      outst = rd_cnt - acc_cnt - int'(hs);
      if (outst > max_out) max_out = outst;
      acc_cnt += int'(hs);
      prev_stall = bus.feat_valid && !bus.feat_ready;
      prev_word = obs;
      if (bus.out_done) begin
        done_cyc = c;
        chk("busy_at_done", {63'd0, bus.out_busy}, 64'd0);
        break;
      end
      @(negedge clk);
    end
    bus.out_state_en = 1'b0;
    chk("word_count", idx, exp_q.size());
    chk("max_outstanding", {63'd0, max_out <= 2}, 64'd1);
    chk("done_seen", {63'd0, done_cyc > 0}, 64'd1);
    chk("done_latency", done_cyc - last_hs, 64'd2);
    if (!rnd) chk("no_bubbles", last_hs - first_hs + 1, exp_q.size());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("post_idle", {60'd0, bus.out_done, bus.out_mem_rd_en, bus.feat_valid, bus.out_busy}, 64'd0);
    end
  endtask

  task automatic short_run(input int fnum, input int cep);
    @(negedge clk);
    bus.frame_num = fnum[6:0]; bus.cep_num = cep[6:0]; bus.out_state_en = 1'b1;
    @(negedge clk);
    bus.out_state_en = 1'b0;
    #1;
    chk("short_done", {61'd0, bus.out_done, bus.out_busy, bus.out_mem_rd_en}, 64'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("short_idle", {60'd0, bus.out_done, bus.out_mem_rd_en, bus.feat_valid, bus.out_busy}, 64'd0);
    end
  endtask

  initial begin
    bit found;
    bus.out_state_en = 1'b0;
    bus.frame_num = 7'd0;
    bus.cep_num = 7'd0;
    bus.feat_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    run_stream(10, 13, 1'b0, -1);
    run_stream(10, 13, 1'b1, -1);
    short_run(4, 13);
    short_run(10, 0);

    // Reset while frame 5 is being read, then restart from scratch.
    @(negedge clk);
    bus.frame_num = 7'd10; bus.cep_num = 7'd13; bus.out_state_en = 1'b1; bus.feat_ready = 1'b1;
    @(negedge clk);
    bus.out_state_en = 1'b0;
    found = 0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (bus.out_mem_rd_en && bus.out_mem_read_addr[13:7] == 7'd5) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_frame5_reached", {63'd0, found}, 64'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk_reset_vals("midrun_rst");
    rst = 1'b0;
    run_stream(10, 13, 1'b0, -1);

    run_stream(10, 13, 1'b0, 40);
    run_stream(6, 4, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
